// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// SIGNED_DIV_EN adds the sign-fixup state used by the signed divide path.
package divider_pkg;

    localparam int DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
`ifdef SIGNED_DIV_EN
        FIN,
        SFIX
`else
        FIN
`endif
    } state_t;

    function automatic logic [31:0] twos_neg(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract.
module divider_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             dividend_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;

    assign shifted = {rem_in, dividend_msb};
    assign q_bit   = (shifted >= {2'b00, divisor});
    assign rem_out = q_bit ? (WIDTH+1)'(shifted - {2'b00, divisor}) : shifted[WIDTH:0];

endmodule

// File: rtl/divider_seq.sv
// Multi-cycle restoring radix-2 divider with start/done handshake and divide-by-zero flag.
// Defining SIGNED_DIV_EN adds the signed_op port and a sign-fixup cycle.
module divider_seq
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A_input,
    input  logic [WIDTH-1:0] B_input,
`ifdef SIGNED_DIV_EN
    input  logic             signed_op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] dq_r;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] quot_next;
    logic             q_bit;

    // dq_r shifts dividend bits out of the top while quotient bits enter at the bottom
    assign quot_next = {dq_r[WIDTH-2:0], q_bit};

`ifdef SIGNED_DIV_EN
    logic sign_a;
    logic sign_b;
    logic signed_r;
    logic neg_q_r;
    logic neg_r_r;

    assign sign_a = signed_op & A_input[WIDTH-1];
    assign sign_b = signed_op & B_input[WIDTH-1];
    assign a_mag  = sign_a ? WIDTH'(twos_neg(32'(A_input))) : A_input;
    assign b_mag  = sign_b ? WIDTH'(twos_neg(32'(B_input))) : B_input;
`else
    assign a_mag = A_input;
    assign b_mag = B_input;
`endif

    divider_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_in      (rem_r),
        .dividend_msb(dq_r[WIDTH-1]),
        .divisor     (div_r),
        .rem_out     (rem_next),
        .q_bit       (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            counter     <= '0;
            rem_r       <= '0;
            dq_r        <= '0;
            div_r       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
            signed_r    <= 1'b0;
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                // FIN shares the accept path so back-to-back operations need no idle cycle
                IDLE, FIN: begin
                    if (start) begin
                        div_r   <= b_mag;
                        dq_r    <= a_mag;
                        rem_r   <= '0;
                        counter <= CNT_W'(WIDTH);
                        busy    <= 1'b1;
`ifdef SIGNED_DIV_EN
                        signed_r <= signed_op;
                        neg_q_r  <= sign_a ^ sign_b;
                        neg_r_r  <= sign_a;
`endif
                        if (B_input == '0) begin
                            state       <= FIN;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= A_input;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                CALC: begin
                    rem_r   <= rem_next;
                    dq_r    <= quot_next;
                    counter <= counter - 1'b1;
                    if (counter == CNT_W'(1)) begin
`ifdef SIGNED_DIV_EN
                        if (signed_r) begin
                            state <= SFIX;
                        end else begin
                            state       <= FIN;
                            done        <= 1'b1;
                            quotient    <= quot_next;
                            remainder   <= rem_next[WIDTH-1:0];
                            div_by_zero <= 1'b0;
                        end
`else
                        state       <= FIN;
                        done        <= 1'b1;
                        quotient    <= quot_next;
                        remainder   <= rem_next[WIDTH-1:0];
                        div_by_zero <= 1'b0;
`endif
                    end
                end
`ifdef SIGNED_DIV_EN
                // Magnitudes were divided; restore signs so results truncate toward zero
                SFIX: begin
                    state       <= FIN;
                    done        <= 1'b1;
                    quotient    <= neg_q_r ? WIDTH'(twos_neg(32'(dq_r))) : dq_r;
                    remainder   <= neg_r_r ? WIDTH'(twos_neg(32'(rem_r[WIDTH-1:0])))
                                           : rem_r[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: 8-bit directed vectors and corner sequences,
// plus an exhaustive sweep on a 4-bit instance.
module tb_divider_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;
`ifdef SIGNED_DIV_EN
    logic       sop;
    logic       sop4;
`endif

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy4;
    logic       done4;
    logic [3:0] quotient4;
    logic [3:0] remainder4;
    logic       div_by_zero4;

    int tests;
    int failures;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         lat;
    } vec_t;

    vec_t vecs[9];

    divider_seq #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .A_input    (a_in),
        .B_input    (b_in),
`ifdef SIGNED_DIV_EN
        .signed_op  (sop),
`endif
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    divider_seq #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start4),
        .A_input    (a4),
        .B_input    (b4),
`ifdef SIGNED_DIV_EN
        .signed_op  (sop4),
`endif
        .busy       (busy4),
        .done       (done4),
        .quotient   (quotient4),
        .remainder  (remainder4),
        .div_by_zero(div_by_zero4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        @(posedge clk);
        #1;
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = 8'($urandom);
        b_in  = 8'($urandom);
    endtask

    // Called #1 after the start edge; counts edges until done is seen
    task automatic waitDone(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic runOp(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] q, input logic [7:0] r, input logic z, input int lat);
        int n;
        applyStimulus(a, b);
        checkOutput({name, " busy"}, 32'(busy), 32'd1);
        waitDone(n);
        if (!done) begin
            checkOutput({name, " timeout"}, 32'(done), 32'd1);
        end else begin
            checkOutput({name, " latency"}, n, lat);
            checkOutput({name, " quotient"}, 32'(quotient), 32'(q));
            checkOutput({name, " remainder"}, 32'(remainder), 32'(r));
            checkOutput({name, " div_by_zero"}, 32'(div_by_zero), 32'(z));
            @(posedge clk);
            #1;
            checkOutput({name, " done pulse"}, 32'(done), 32'd0);
            checkOutput({name, " idle"}, 32'(busy), 32'd0);
            checkOutput({name, " hold"}, {24'd0, quotient}, 32'(q));
        end
    endtask

    task automatic runOp4(input logic [3:0] a, input logic [3:0] b);
        int n;
        logic [3:0] eq;
        logic [3:0] er;
        int elat;
        if (b == 4'd0) begin
            eq   = 4'hF;
            er   = a;
            elat = 0;
        end else begin
            eq   = a / b;
            er   = a % b;
            elat = 4;
        end
        @(posedge clk);
        #1;
        start4 = 1'b1;
        a4     = a;
        b4     = b;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput($sformatf("w4 %0d/%0d", a, b),
                    {n[7:0], 15'd0, done4, quotient4, remainder4},
                    {elat[7:0], 15'd0, 1'b1, eq, er});
    endtask

    initial begin
        int n;
        int seen;
        tests    = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a_in     = '0;
        b_in     = '0;
        start4   = 1'b0;
        a4       = '0;
        b4       = '0;
`ifdef SIGNED_DIV_EN
        sop      = 1'b0;
        sop4     = 1'b0;
`endif

        vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 8};
        vecs[1] = '{8'd13,  8'd0,   8'hFF,  8'd13,  1'b1, 0};
        vecs[2] = '{8'd9,   8'd3,   8'd3,   8'd0,   1'b0, 8};
        vecs[3] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8};
        vecs[4] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 8};
        vecs[5] = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0, 8};
        vecs[6] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 8};
        vecs[7] = '{8'd254, 8'd16,  8'd15,  8'd14,  1'b0, 8};
        vecs[8] = '{8'd255, 8'd0,   8'hFF,  8'hFF,  1'b1, 0};

        #3;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset outputs", {15'd0, div_by_zero, quotient, remainder}, 32'd0);
        #9;
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                  vecs[i].z, vecs[i].lat);
        end

        // start during CALC is ignored; start held into FIN launches the next op
        @(posedge clk);
        #1;
        start = 1'b1;
        a_in  = 8'd100;
        b_in  = 8'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        a_in  = 8'd5;
        b_in  = 8'd1;
        n = 2;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("ignore latency", n, 8);
        checkOutput("ignore result", {16'd0, quotient, remainder}, {16'd0, 8'd11, 8'd1});
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("b2b busy", 32'(busy), 32'd1);
        checkOutput("b2b done low", 32'(done), 32'd0);
        waitDone(n);
        checkOutput("b2b latency", n, 8);
        checkOutput("b2b result", {15'd0, done, quotient, remainder}, {15'd0, 1'b1, 8'd5, 8'd0});
        @(posedge clk);
        #1;

        // asynchronous reset in the middle of CALC
        applyStimulus(8'd200, 8'd7);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort outputs", {14'd0, busy, done, quotient, remainder}, 32'd0);
        checkOutput("abort dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        checkOutput("abort no done", seen, 0);
        runOp("after abort", 8'd100, 8'd9, 8'd11, 8'd1, 1'b0, 8);

`ifdef SIGNED_DIV_EN
        sop = 1'b1;
        runOp("s -7/2",    8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 9);
        runOp("s -128/-1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9);
        runOp("s 7/-2",    8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 9);
        runOp("s -7/0",    8'hF9, 8'h00, 8'hFF, 8'hF9, 1'b1, 0);
        sop = 1'b0;
        runOp("u 249/2",   8'hF9, 8'h02, 8'd124, 8'd1, 1'b0, 8);
`endif

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                runOp4(4'(a), 4'(b));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
